// File: rtl/hawk_cpu_stall_wr.sv
// Write-path stall: holds each AXI4 write address until the hawk lookup grants it, then issues it with the translated ppa.
// Optional HAWK_WR_BYPASS_EN: hawk_inactive turns the AW/W path into a plain wire.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 1
`endif

package hacd_pkg;
  localparam int HPPA_W = 52;
  typedef struct packed {
    logic              allow_access;
    logic [HPPA_W-1:0] ppa;
  } hawk_cpu_ovrd_pkt_t;
  typedef struct packed {
    logic              valid;
    logic [HPPA_W-1:0] hppa;
  } cpu_reqpkt_t;
  typedef struct packed {
    logic [63:0] lastaddr0;
    logic [63:0] lastaddr1;
    logic [63:0] awcount0;
    logic [63:0] awcount1;
    logic [63:0] resp_count0;
    logic [63:0] resp_count1;
    logic        overflow;
    logic        bus_error;
    logic [1:0]  fsm_state;
  } stall_debug_bus;
endpackage

module hawk_cpu_stall_wr #(
  parameter int DATA_WIDTH   = `HACD_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH   = `HACD_AXI4_ADDR_WIDTH,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int ID_WIDTH     = `HACD_AXI4_ID_WIDTH,
  parameter int AWUSER_WIDTH = `HACD_AXI4_USER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  hacd_pkg::hawk_cpu_ovrd_pkt_t hawk_cpu_ovrd_pkt,
  output hacd_pkg::cpu_reqpkt_t        cpu_reqpkt,
  input  logic                         hawk_inactive,
  input  logic [ID_WIDTH-1:0]          s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awlock,
  input  logic [3:0]                   s_axi_awcache,
  input  logic [2:0]                   s_axi_awprot,
  input  logic [3:0]                   s_axi_awqos,
  input  logic [3:0]                   s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0]      s_axi_awuser,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]        s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic [AWUSER_WIDTH-1:0]      s_axi_wuser,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [ID_WIDTH-1:0]          s_axi_bid,
  output logic [1:0]                   s_axi_bresp,
  output logic [AWUSER_WIDTH-1:0]      s_axi_buser,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [ID_WIDTH-1:0]          m_axi_awid,
  output logic [ADDR_WIDTH-1:0]        m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic                         m_axi_awlock,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic [3:0]                   m_axi_awqos,
  output logic [3:0]                   m_axi_awregion,
  output logic [AWUSER_WIDTH-1:0]      m_axi_awuser,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_WIDTH-1:0]        m_axi_wdata,
  output logic [STRB_WIDTH-1:0]        m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic [AWUSER_WIDTH-1:0]      m_axi_wuser,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [ID_WIDTH-1:0]          m_axi_bid,
  input  logic [1:0]                   m_axi_bresp,
  input  logic [AWUSER_WIDTH-1:0]      m_axi_buser,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  output hacd_pkg::stall_debug_bus     stall_wr_dbg_bus
);
  localparam int HW = hacd_pkg::HPPA_W;

  typedef enum logic [1:0] {IDLE, WAIT, ADDR, DATA} state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    logic [AWUSER_WIDTH-1:0] user;
  } aw_t;

  state_e  state_q;
  aw_t     aw_q, s_aw, m_aw;
  logic    awready_q, awvalid_q, allow_q;
  logic [HW-1:0] ppa_q;
  logic    bypass, aw_cap, w_open;
  hacd_pkg::stall_debug_bus dbg_q, dbg_d;

`ifdef HAWK_WR_BYPASS_EN
  assign bypass = hawk_inactive;
`else
  logic unused_inactive;
  assign bypass = 1'b0;
  assign unused_inactive = hawk_inactive;
`endif

  assign s_aw = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                 s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser};
  assign m_aw = bypass ? s_aw : aw_q;
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
          m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser} = m_aw;
  assign m_axi_awvalid = bypass ? s_axi_awvalid : awvalid_q;
  assign s_axi_awready = bypass ? m_axi_awready : awready_q;
  assign aw_cap        = !bypass && s_axi_awvalid && awready_q;

  // Write data may only flow once memory has taken the matching address.
  assign w_open       = bypass || (state_q == DATA);
  assign m_axi_wvalid = w_open && s_axi_wvalid;
  assign s_axi_wready = w_open && m_axi_wready;
  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wuser  = s_axi_wuser;

  assign s_axi_bid    = m_axi_bid;
  assign s_axi_bresp  = m_axi_bresp;
  assign s_axi_buser  = m_axi_buser;
  assign s_axi_bvalid = m_axi_bvalid;
  assign m_axi_bready = s_axi_bready;

  always_comb begin
    cpu_reqpkt.valid = !bypass && (state_q == WAIT) && !allow_q && !hawk_cpu_ovrd_pkt.allow_access;
    cpu_reqpkt.hppa  = HW'(aw_q.addr[ADDR_WIDTH-1:12]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_q      <= '0;
      awready_q <= 1'b0;
      awvalid_q <= 1'b0;
      allow_q   <= 1'b0;
      ppa_q     <= '0;
    end else begin
      if (hawk_cpu_ovrd_pkt.allow_access) ppa_q <= hawk_cpu_ovrd_pkt.ppa;
      // A grant in the capture cycle belongs to the new request, so it survives.
      allow_q <= aw_cap ? hawk_cpu_ovrd_pkt.allow_access : (allow_q | hawk_cpu_ovrd_pkt.allow_access);
      unique case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (aw_cap) begin
            aw_q      <= s_aw;
            awready_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: if (allow_q) begin
          aw_q.addr <= {ppa_q[ADDR_WIDTH-13:0], aw_q.addr[11:0]};
          awvalid_q <= 1'b1;
          state_q   <= ADDR;
        end
        ADDR: if (m_axi_awready) begin
          awvalid_q <= 1'b0;
          state_q   <= DATA;
        end
        DATA: if (s_axi_wvalid && m_axi_wready && s_axi_wlast) begin
          awready_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dbg_d = dbg_q;
    if (s_axi_awvalid && s_axi_awready) begin
      if (s_axi_awid == ID_WIDTH'(0)) begin
        dbg_d.lastaddr0 = 64'(s_axi_awaddr);
        dbg_d.awcount0  = dbg_q.awcount0 + 64'd1;
      end else if (s_axi_awid == ID_WIDTH'(1)) begin
        dbg_d.lastaddr1 = 64'(s_axi_awaddr);
        dbg_d.awcount1  = dbg_q.awcount1 + 64'd1;
      end else begin
        dbg_d.overflow = 1'b1;
      end
    end
    if (m_axi_bvalid && s_axi_bready) begin
      if (m_axi_bresp != 2'b00) dbg_d.bus_error = 1'b1;
      if (m_axi_bid > ID_WIDTH'(1)) dbg_d.overflow = 1'b1;
      else if (m_axi_bresp == 2'b00) begin
        if (m_axi_bid == ID_WIDTH'(0)) dbg_d.resp_count0 = dbg_q.resp_count0 + 64'd1;
        else                           dbg_d.resp_count1 = dbg_q.resp_count1 + 64'd1;
      end
    end
    if ((&dbg_q.awcount0) || (&dbg_q.awcount1) || (&dbg_q.resp_count0) || (&dbg_q.resp_count1))
      dbg_d.overflow = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_q           <= '0;
      dbg_q.lastaddr0 <= '1;
      dbg_q.lastaddr1 <= '1;
    end else begin
      dbg_q <= dbg_d;
    end
  end

  always_comb begin
    stall_wr_dbg_bus           = dbg_q;
    stall_wr_dbg_bus.fsm_state = state_q;
  end
endmodule
